tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Time-division demultiplexer: the receive end of a bit-serial TDM link whose transmit side
//  selects channels onto one wire with mux2to1 stages. Hunts for frame sync, deserialises
//  CHANNELS words of WIDTH bits and presents all of them in parallel, double-buffered.
//  Sits between the board serial input pin and LEDR/HEX display logic.
// PARAMETERS
//  CHANNELS  4  number of time slots per frame (>=2)
//  WIDTH     8  bits per slot (>=1)
// PORTS
//  clock        in   1               system clock, rising edge
//  resetn       in   1               asynchronous active-low reset
//  bit_en       in   1               bit strobe; serial_in/frame_sync sampled only when high
//  serial_in    in   1               serial data, MSB of each slot first, slot 0 first
//  frame_sync   in   1               high with the first bit of every frame
//  ch_data      out  CHANNELS*WIDTH  last good frame; slot k at [k*WIDTH +: WIDTH]
//  frame_valid  out  1               one-clock pulse when ch_data updates
//  sync_error   out  1               one-clock pulse on a framing fault
//  locked       out  1               high while in RECV
// BEHAVIOUR
//  - Reset: ch_data=0, frame_valid=0, sync_error=0, locked=0, state=HUNT, bit counter=0,
//    shift/holding regs=0. Reset mid-frame discards the partial frame.
//  - FRAME_BITS = CHANNELS*WIDTH (+1 with TDM_PARITY_EN). Counter cnt in 0..FRAME_BITS-1.
//  - Nothing happens on clocks with bit_en=0 (all state held; pulses drop to 0).
//  - HUNT: bit_en&frame_sync -> bit taken as frame bit 0, cnt=1, -> RECV.
//    bit_en&!frame_sync -> bit discarded, stay HUNT, no error.
//  - RECV, bit_en high, priority order:
//    1. cnt==0 & !frame_sync: sync_error pulse, bit discarded, -> HUNT.
//    2. cnt!=0 & frame_sync: sync_error pulse, partial frame dropped, bit taken as bit 0, cnt=1.
//    3. else shift bit in; every WIDTH bits the word goes to holding slot cnt/WIDTH.
//    4. final bit (cnt==FRAME_BITS-1): on that same edge ch_data <= holding (incl. final word),
//       frame_valid=1 for one clock, cnt=0, stay RECV.
//  - Latency: ch_data/frame_valid change on the edge that samples the frame's last bit.
//  - ch_data never shows a partial frame; it holds until the next good frame.
//  - frame_valid and sync_error are never high on the same clock.
//  - locked = (state==RECV), registered.
// CONFIGURATION
//  TDM_PARITY_EN defined: one extra even-parity bit after the last slot (covers all
//   CHANNELS*WIDTH data bits). Match -> commit as above. Mismatch -> no commit, no
//   frame_valid, sync_error pulse, cnt=0, stay RECV.
//  TDM_PARITY_EN undefined: no parity bit, FRAME_BITS = CHANNELS*WIDTH, no parity logic.
// TESTING (CHANNELS=4, WIDTH=8, bit_en every 3rd clock unless noted)
//  1. Reset low mid-stream -> all outputs 0 asynchronously, locked=0 until next sync.
//  2. Frame A5,3C,FF,00 with sync on bit 0 -> ch_data=32'h00FF3CA5, one frame_valid, locked=1.
//  3. Two back-to-back frames (bit_en tied high) 01,02,03,04 then 10,20,30,40 ->
//     32'h04030201 then 32'h40302010, exactly two frame_valid pulses.
//  4. frame_sync at bit 13 of a frame -> sync_error pulse, ch_data unchanged, frame restarting
//     at that bit commits correctly.
//  5. No sync on expected bit 0 -> sync_error, locked=0, ch_data held; later sync relocks.
//  6. TDM_PARITY_EN: frame 80,00,00,00 with parity 1 -> commit; parity 0 -> sync_error, no update.

Source files
------------

// File: rtl/tdm_demux.sv
// Bit-serial TDM receiver: hunts for frame sync, deserialises CHANNELS x WIDTH slots and
// presents each good frame in parallel. Define TDM_PARITY_EN for a trailing even-parity bit.
module tdm_demux #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        bit_en,
  input  logic                        serial_in,
  input  logic                        frame_sync,
  output logic [CHANNELS*WIDTH-1:0]   ch_data,
  output logic                        frame_valid,
  output logic                        sync_error,
  output logic                        locked
);

  localparam int unsigned DataBits = CHANNELS * WIDTH;
`ifdef TDM_PARITY_EN
  localparam int unsigned FrameBits = DataBits + 1;
`else
  localparam int unsigned FrameBits = DataBits;
`endif
  localparam int unsigned CntW = $clog2(FrameBits);

  typedef enum logic [0:0] {StHunt, StRecv} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]      word_q, word_d;
  logic [DataBits-1:0]   hold_q, hold_d;
  logic [DataBits-1:0]   ch_data_q, ch_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  sync_error_q, sync_error_d;

  int unsigned           pos;
  logic                  take;
  logic                  commit_ok;
  logic [WIDTH-1:0]      word_nxt;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    hold_d        = hold_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    sync_error_d  = 1'b0;
    take          = 1'b0;
    pos           = 32'(cnt_q);
    word_nxt      = WIDTH'({word_q, serial_in});
`ifdef TDM_PARITY_EN
    // Even parity: data ones plus the parity bit must come to an even count.
    commit_ok     = ((^hold_q) == serial_in);
`else
    commit_ok     = 1'b1;
`endif

    if (bit_en) begin
      if (state_q == StHunt) begin
        if (frame_sync) begin
          take    = 1'b1;
          pos     = 0;
          state_d = StRecv;
        end
      end else if (cnt_q == '0 && !frame_sync) begin
        sync_error_d = 1'b1;
        state_d      = StHunt;
        cnt_d        = '0;
      end else if (cnt_q != '0 && frame_sync) begin
        // Early sync: drop the partial frame and restart on this bit.
        sync_error_d = 1'b1;
        take         = 1'b1;
        pos          = 0;
      end else begin
        take = 1'b1;
      end
    end

    if (take) begin
      word_d = word_nxt;
      cnt_d  = (pos == FrameBits - 1) ? '0 : CntW'(pos + 1);
      if (pos < DataBits && (pos % WIDTH) == WIDTH - 1) begin
        hold_d[(pos / WIDTH) * WIDTH +: WIDTH] = word_nxt;
      end
      if (pos == FrameBits - 1) begin
        if (commit_ok) begin
          ch_data_d     = hold_d;
          frame_valid_d = 1'b1;
        end else begin
          sync_error_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StHunt;
      cnt_q         <= '0;
      word_q        <= '0;
      hold_q        <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      hold_q        <= hold_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      sync_error_q  <= sync_error_d;
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_error  = sync_error_q;
  assign locked      = (state_q == StRecv);

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (CHANNELS=4, WIDTH=8); TDM_PARITY_EN adds the parity cases.
module tb_tdm_demux;

  logic        clock;
  logic        resetn;
  logic        bit_en;
  logic        serial_in;
  logic        frame_sync;
  logic [31:0] ch_data;
  logic        frame_valid;
  logic        sync_error;
  logic        locked;

  tdm_demux #(.CHANNELS(4), .WIDTH(8)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bit_en      (bit_en),
    .serial_in   (serial_in),
    .frame_sync  (frame_sync),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .sync_error  (sync_error),
    .locked      (locked)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          fv_cnt = 0;
  int          exp_frames = 0;
  logic [31:0] ch_exp = 32'h0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_ev(input logic err, input logic [31:0] data);
    ev_t e;
    e.err  = err;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; leaves bit_en high when gap==1 so bits run back to back.
  task automatic send_bit(input logic b, input logic s, input int gap);
    bit_en     = 1'b1;
    serial_in  = b;
    frame_sync = s;
    @(negedge clock);
    if (gap > 1) begin
      bit_en     = 1'b0;
      serial_in  = 1'b0;
      frame_sync = 1'b0;
      repeat (gap - 1) @(negedge clock);
    end
  endtask

  task automatic idle();
    bit_en     = 1'b0;
    serial_in  = 1'b0;
    frame_sync = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_partial(input logic [31:0] d, input int nbits, input int gap);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      for (int b = 7; b >= 0; b--) begin
        if (n < nbits) send_bit(d[k*8+b], (n == 0), gap);
        n++;
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int gap, input logic restart,
                            input logic par_good);
    logic p;
    p = ^d;
    for (int k = 0; k < 4; k++) begin
      for (int b = 7; b >= 0; b--) begin
        if (k == 0 && b == 7 && restart) push_ev(1'b1, ch_exp);
`ifndef TDM_PARITY_EN
        if (k == 3 && b == 0) begin
          push_ev(1'b0, d);
          ch_exp = d;
          exp_frames++;
        end
`endif
        send_bit(d[k*8+b], (k == 0 && b == 7), gap);
      end
    end
`ifdef TDM_PARITY_EN
    if (par_good) begin
      push_ev(1'b0, d);
      ch_exp = d;
      exp_frames++;
      send_bit(p, 1'b0, gap);
    end else begin
      push_ev(1'b1, ch_exp);
      send_bit(~p, 1'b0, gap);
    end
`else
    if (par_good !== 1'b1) $display("note: parity request ignored without TDM_PARITY_EN");
`endif
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (frame_valid || sync_error) begin
        check("pulse_exclusive", 32'(frame_valid && sync_error), 32'h0);
        if (frame_valid) fv_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'h0, frame_valid, sync_error}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'(sync_error), 32'(e.err));
          check("ch_data", ch_data, e.data);
        end
      end
    end
  end

  initial begin
    resetn     = 1'b0;
    bit_en     = 1'b0;
    serial_in  = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ch_data", ch_data, 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_pulses", {30'h0, frame_valid, sync_error}, 32'h0);
    resetn = 1'b1;
    @(negedge clock);

    // Hunting: unsynced bits are silently dropped.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 3);
    check("hunt_locked", 32'(locked), 32'h0);

    send_frame(32'h00FF3CA5, 3, 1'b0, 1'b1);
    idle();
    check("lock_after_frame", 32'(locked), 32'h1);

    // Asynchronous reset in the middle of a frame.
    send_partial(32'h12345678, 10, 3);
    #2 resetn = 1'b0;
    #1;
    check("async_ch_data", ch_data, 32'h0);
    check("async_locked", 32'(locked), 32'h0);
    check("async_pulses", {30'h0, frame_valid, sync_error}, 32'h0);
    ch_exp = 32'h0;
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0, 3);
    check("post_rst_locked", 32'(locked), 32'h0);

    send_frame(32'h04030201, 1, 1'b0, 1'b1);
    send_frame(32'h40302010, 1, 1'b0, 1'b1);
    idle();

    // Sync arrives at bit 13: error, then the restarted frame commits.
    send_partial(32'hDEADBEEF, 13, 3);
    send_frame(32'h11223344, 3, 1'b1, 1'b1);
    idle();

    // Missing sync on the expected bit 0.
    push_ev(1'b1, ch_exp);
    send_bit(1'b0, 1'b0, 3);
    idle();
    check("unlock_locked", 32'(locked), 32'h0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 3);
    send_frame(32'hCAFE0042, 3, 1'b0, 1'b1);
    idle();
    check("relock_locked", 32'(locked), 32'h1);

`ifdef TDM_PARITY_EN
    send_frame(32'h00000080, 3, 1'b0, 1'b1);
    send_frame(32'h00000080, 3, 1'b0, 1'b0);
    idle();
`endif

    repeat (10) @(negedge clock);
    check("events_left", 32'(exp_q.size()), 32'h0);
    check("frame_valid_count", 32'(fv_cnt), 32'(exp_frames));
    check("final_ch_data", ch_data, ch_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
